// File: rtl/arm_enc_pkg.sv
// arm_enc_pkg: shared kinds, field constants and FSM states for the ARM instruction encoder.
// Rev 1.0 -- optional TERM state present only when ARM_ENC_TERM_EN is defined.
`default_nettype none

package arm_enc_pkg;

  typedef enum logic [3:0] {
    KIND_ADD = 4'd0,
    KIND_SUB = 4'd1,
    KIND_AND = 4'd2,
    KIND_ORR = 4'd3,
    KIND_LSL = 4'd4,
    KIND_LDR = 4'd5,
    KIND_STR = 4'd6,
    KIND_B   = 4'd7,
    KIND_BL  = 4'd8
  } kind_e;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0]  COND_AL   = 4'hE;
  localparam logic [31:0] TERM_WORD = 32'hEAFF_FFFE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
`ifdef ARM_ENC_TERM_EN
    ST_ERR  = 2'd2,
    ST_TERM = 2'd3
`else
    ST_ERR  = 2'd2
`endif
  } state_e;

endpackage

`default_nettype wire

// File: rtl/arm_word_pack.sv
// arm_word_pack: combinational packer from symbolic request fields to a 32-bit ARM word.
// Rev 1.0
`default_nettype none

module arm_word_pack
  import arm_enc_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [3:0]  i_cond,
  input  logic        i_s,
  input  logic        i_imm,
  input  logic [3:0]  i_rn,
  input  logic [3:0]  i_rd,
  input  logic [11:0] i_src2,
  input  logic [23:0] i_imm24,
  output logic [31:0] o_word,
  output logic        o_illegal
);

  logic [3:0] w_cmd;
  logic [3:0] w_rn_dp;
  logic       w_is_dp;

  always_comb begin
    w_cmd   = CMD_ADD;
    w_is_dp = 1'b1;
    case (i_kind)
      KIND_ADD: w_cmd = CMD_ADD;
      KIND_SUB: w_cmd = CMD_SUB;
      KIND_AND: w_cmd = CMD_AND;
      KIND_ORR: w_cmd = CMD_ORR;
      KIND_LSL: w_cmd = CMD_MOV;
      default:  w_is_dp = 1'b0;
    endcase
  end

  // MOV-class shifts have no first operand register
  assign w_rn_dp = (i_kind == KIND_LSL) ? 4'd0 : i_rn;

  always_comb begin
    o_word    = '0;
    o_illegal = 1'b0;
    if (w_is_dp) begin
      o_word = {i_cond, OP_DP, i_imm, w_cmd, i_s, w_rn_dp, i_rd, i_src2};
    end else begin
      case (i_kind)
        KIND_LDR: o_word = {i_cond, OP_MEM, ~i_imm, 4'b1100, 1'b1, i_rn, i_rd, i_src2};
        KIND_STR: o_word = {i_cond, OP_MEM, ~i_imm, 4'b1100, 1'b0, i_rn, i_rd, i_src2};
        KIND_B:   o_word = {i_cond, OP_BR, 1'b1, 1'b0, i_imm24};
        KIND_BL:  o_word = {i_cond, OP_BR, 1'b1, 1'b1, i_imm24};
        default:  o_illegal = 1'b1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/arm_instr_encoder.sv
// arm_instr_encoder: handshake front-end, FSM and registered IMEM write port around arm_word_pack.
// Rev 1.0 -- define ARM_ENC_TERM_EN to append a branch-to-self word after stop.
`default_nettype none

module arm_instr_encoder
  import arm_enc_pkg::*;
#(
  parameter int ADDR_W  = 6,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_start,
  input  logic [ADDR_W-1:0]  i_start_addr,
  input  logic               i_stop,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic [3:0]         i_req_kind,
  input  logic [3:0]         i_req_cond,
  input  logic               i_req_s,
  input  logic               i_req_imm,
  input  logic [3:0]         i_req_rn,
  input  logic [3:0]         i_req_rd,
  input  logic [11:0]        i_req_src2,
  input  logic [23:0]        i_req_imm24,
  output logic               o_wr_valid,
  input  logic               i_wr_ready,
  output logic [ADDR_W-1:0]  o_wr_addr,
  output logic [31:0]        o_wr_data,
  output logic               o_busy,
  output logic               o_err,
  output logic [COUNT_W-1:0] o_count
);

  state_e             r_state;
  state_e             w_state_next;
  logic               r_stopping;
  logic               r_wr_valid;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [31:0]        r_wr_data;
  logic [ADDR_W-1:0]  r_addr;
  logic [COUNT_W-1:0] r_count;
  logic               r_err;

  logic [31:0]        w_word;
  logic               w_illegal;
  logic               w_req_ready;
  logic               w_term_load;
  logic               w_accept;
  logic               w_hs;
  logic               w_drained;
  logic               w_stop_req;
  logic               w_start_load;
  logic [ADDR_W-1:0]  w_addr_next;

  arm_word_pack u_pack (
    .i_kind    (i_req_kind),
    .i_cond    (i_req_cond),
    .i_s       (i_req_s),
    .i_imm     (i_req_imm),
    .i_rn      (i_req_rn),
    .i_rd      (i_req_rd),
    .i_src2    (i_req_src2),
    .i_imm24   (i_req_imm24),
    .o_word    (w_word),
    .o_illegal (w_illegal)
  );

  assign w_hs         = r_wr_valid && i_wr_ready;
  assign w_drained    = !r_wr_valid || i_wr_ready;
  assign w_accept     = i_req_valid && w_req_ready;
  assign w_stop_req   = (r_state == ST_RUN) && (i_stop || r_stopping);
  assign w_start_load = i_start && ((r_state == ST_IDLE) || (r_state == ST_ERR));
  // r_addr tracks the pending word; a word loaded during a retire lands one slot later
  assign w_addr_next  = r_addr + {{(ADDR_W-1){1'b0}}, w_hs};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_stopping <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_stopping <= w_stop_req && !w_drained;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE, ST_ERR: begin
        if (w_start_load) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        if (w_accept && w_illegal) begin
          w_state_next = ST_ERR;
        end else if (w_stop_req && w_drained) begin
`ifdef ARM_ENC_TERM_EN
          w_state_next = ST_TERM;
`else
          w_state_next = ST_IDLE;
`endif
        end
      end
`ifdef ARM_ENC_TERM_EN
      ST_TERM: begin
        if (w_hs) w_state_next = ST_IDLE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_ready = (r_state == ST_RUN) && !i_stop && !r_stopping && w_drained;
    w_term_load = 1'b0;
`ifdef ARM_ENC_TERM_EN
    w_term_load = w_stop_req && w_drained;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_addr     <= '0;
      r_count    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept && !w_illegal) begin
        r_wr_valid <= 1'b1;
        r_wr_data  <= w_word;
        r_wr_addr  <= w_addr_next;
      end else if (w_term_load) begin
        r_wr_valid <= 1'b1;
        r_wr_data  <= TERM_WORD;
        r_wr_addr  <= w_addr_next;
      end else if (w_hs) begin
        r_wr_valid <= 1'b0;
      end

      if (w_start_load) begin
        r_addr  <= i_start_addr;
        r_count <= '0;
      end else if (w_hs) begin
        r_addr <= r_addr + ADDR_W'(1);
        if (r_count != {COUNT_W{1'b1}}) r_count <= r_count + COUNT_W'(1);
      end

      if (w_start_load) r_err <= 1'b0;
      else if (w_accept && w_illegal) r_err <= 1'b1;
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_wr_valid  = r_wr_valid;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_busy      = (r_state != ST_IDLE) || r_wr_valid;
  assign o_err       = r_err;
  assign o_count     = r_count;

endmodule

`default_nettype wire

// File: doc/arm_instr_encoder.md
Name: arm_instr_encoder

Overview:
Inverse of the pipeline's control-unit instruction decoder. Accepts symbolic instruction requests (kind, cond, registers, operands) over a valid/ready handshake. Packs each request into a 32-bit ARM machine word and streams the words into instruction memory through a registered write port with an auto-incrementing word address. Used by the program loader and self-test harness to build programs in IMEM.

Parameters:
ADDR_W, 6, word-address width; the write address wraps modulo 2**ADDR_W
COUNT_W, 16, width of the emitted-word counter (saturates)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: load base address from start_addr and enter RUN
start_addr  in  ADDR_W  first word address
stop  in  1  pulse: finish in-flight word, return to IDLE
req_valid  in  1  request present
req_ready  out  1  request accepted when valid&ready
req_kind  in  4  0 ADD,1 SUB,2 AND,3 ORR,4 LSL(MOV),5 LDR,6 STR,7 B,8 BL; 9-15 illegal
req_cond  in  4  condition field
req_s  in  1  S bit (DP kinds only)
req_imm  in  1  1 = immediate operand/offset
req_rn  in  4  Rn
req_rd  in  4  Rd (Rt for LDR/STR)
req_src2  in  12  Src2 / offset field
req_imm24  in  24  branch offset (B/BL)
wr_valid  out  1  IMEM write valid
wr_ready  in  1  IMEM accepts write
wr_addr  out  ADDR_W  word address
wr_data  out  32  encoded instruction
busy  out  1  state != IDLE or wr_valid
err  out  1  sticky illegal-kind flag
count  out  COUNT_W  words written since start

Behaviour:
- Reset: state IDLE; req_ready, wr_valid, busy, err = 0; wr_addr, wr_data, count = 0.
- States: IDLE, RUN, ERR (plus TERM when ARM_ENC_TERM_EN is defined).
- IDLE -> RUN on start: addr <= start_addr, count <= 0, err <= 0. start is ignored outside IDLE and ERR.
- RUN: req_ready = !wr_valid | wr_ready (single-entry output register, full throughput).
- Accept: on valid&ready, wr_data <= encoded word, wr_valid <= 1 the next cycle, wr_addr <= current addr. Latency is 1 cycle from acceptance to wr_valid.
- While wr_valid & !wr_ready, wr_addr and wr_data are held stable.
- On wr_valid&wr_ready: addr increments, wrapping 2**ADDR_W-1 -> 0; count increments and saturates at all-ones.
- Encoding, common fields: [31:28]=cond, [27:26]=op, [25:20]=funct, [19:16]=Rn, [15:12]=Rd, [11:0]=src2.
  - DP kinds: op=00, funct={imm,cmd,s} with cmd ADD 0100, SUB 0010, AND 0000, ORR 1100, LSL 1101. For LSL, Rn is forced to 0.
  - LDR/STR: op=01, funct={~imm,1,1,0,0,L}, with L=1 for LDR and L=0 for STR.
  - B/BL: [27:24]={10,1,L}, [23:0]=imm24.
- Illegal kind: the request is consumed without a write, err <= 1, state -> ERR. In ERR, req_ready=0 and any pending write still drains. Leave ERR only by start (clears err) or reset.
- stop in RUN: req_ready drops in the same cycle, the pending write drains, then IDLE.
- start and stop in the same cycle in IDLE: start wins.
- Reset mid-write: the word is lost and the port goes idle immediately (asynchronous clear).

Optional Feature:
- Macro: ARM_ENC_TERM_EN.
- Defined: on stop, after the drain, state TERM emits one extra word 0xEAFFFFFE (B . , branch-to-self) at the next address, then goes to IDLE. count includes this word.
- Undefined: stop goes directly to IDLE after the drain; no TERM state.

Decomposition:
- Package arm_enc_pkg: kind enum, cmd constants (CMD_ADD..CMD_MOV), op constants (OP_DP/OP_MEM/OP_BR), COND_AL=4'hE, TERM_WORD=32'hEAFFFFFE, FSM state enum.
- Sub-module arm_word_pack: purely combinational kind+fields -> {word, illegal}. The top level holds the FSM, output register and counters.

Test Plan:
- start_addr=0; ADD cond E, imm=1, Rn=2, Rd=1, src2=5 -> wr_data 0xE2821005 @ addr 0, one cycle after acceptance.
- SUB s=1, imm=1, Rn=3, Rd=3, src2=1 -> 0xE2533001; STR imm=1, Rn=0, Rd=1, src2=4 -> 0xE5801004; LDR with the same fields -> 0xE5901004.
- B imm24=0xFFFFFE -> 0xEAFFFFFE; BL imm24=0x000010 -> 0xEB000010; LSL s=0, Rd=4, src2=0x102 -> 0xE1A04102 (Rn forced to 0).
- wr_ready held low for 5 cycles with req_valid high -> wr_addr and wr_data stable, exactly one request absorbed; start_addr=63 then 2 words -> addresses 63, 0.
- req_kind=12 -> no write, err=1, req_ready=0; then start -> err=0, back to RUN.
- stop with ARM_ENC_TERM_EN defined -> final word 0xEAFFFFFE at the next address, count +1. Without the macro -> no extra write.
